tap_decoder: RTL and testbench
==============================

TAP_DECODER -- requirements
Module: tap_decoder

Interface
REQ-001 The block SHALL have parameter sim, default 0: 0 = hardware timing window, 1 = shortened window for simulation.
REQ-002 The block SHALL have parameter WIN_HW, default 12500000: tap window in clk cycles when sim=0 (250 ms at 50 MHz).
REQ-003 The block SHALL have parameter WIN_SIM, default 8: tap window in clk cycles when sim=1.
REQ-004 The block SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port PulseIn, input, 1 bit: one-cycle press pulse from the button processing unit output.
REQ-007 The block SHALL have port SingleTap, output, 1 bit: one-cycle pulse, sequence of one tap.
REQ-008 The block SHALL have port DoubleTap, output, 1 bit: one-cycle pulse, sequence of two taps.
REQ-009 The block SHALL have port TripleTap, output, 1 bit: one-cycle pulse, sequence of three taps.
REQ-010 The block SHALL have port TapCount, output, 2 bits: taps accepted in the open sequence.
REQ-011 The block SHALL have port Busy, output, 1 bit: high while a sequence is open.

Function
REQ-012 The window WIN SHALL be WIN_SIM when sim=1, else WIN_HW; WIN SHALL be at least 2; the timer SHALL be sized to hold WIN-1 without overflow.
REQ-013 The FSM SHALL have states IDLE, ONE, TWO; Busy SHALL be high exactly in ONE and TWO; TapCount SHALL be 0/1/2 in IDLE/ONE/TWO.
REQ-014 IDLE with PulseIn=1 at an edge SHALL go to ONE and clear the timer to 0.
REQ-015 In ONE/TWO the timer SHALL increment by 1 per edge with PulseIn=0; PulseIn=1 SHALL clear it to 0.
REQ-016 A tap sampled at edge E0 SHALL accept a continuation tap at any of edges E1..E(WIN); timer value before edge Ek is k-1.
REQ-017 ONE with PulseIn=1 SHALL go to TWO; timer cleared.
REQ-018 ONE with PulseIn=0 and timer=WIN-1 SHALL register SingleTap=1 at that edge and go to IDLE.
REQ-019 TWO with PulseIn=0 and timer=WIN-1 SHALL register DoubleTap=1 at that edge and go to IDLE.
REQ-020 Tap versus expiry on the same edge: the tap SHALL win, and no output SHALL be emitted.
REQ-021 All outputs SHALL be registered, and each tap output SHALL be high for exactly one cycle.
REQ-022 At most one tap output SHALL be high in any cycle.
REQ-023 A PulseIn sampled at the edge that registers a tap output SHALL be handled by the transition rules of the state in effect before that edge.
REQ-024 A PulseIn in the cycle after an output, with the FSM in IDLE, SHALL start a new sequence normally.
REQ-025 PulseIn held high for N consecutive cycles SHALL count as N taps; the upstream block guarantees single-cycle pulses.

Reset
REQ-026 reset=0 SHALL immediately, without waiting for clk, force: state IDLE, timer 0, SingleTap/DoubleTap/TripleTap 0, TapCount 0, Busy 0.
REQ-027 Reset mid-sequence SHALL discard the open sequence; no output SHALL be emitted for it after release.
REQ-028 The first edge after reset release SHALL apply normal IDLE rules.

Configuration
REQ-029 Macro TRIPLE_TAP_EN defined: TWO with PulseIn=1 SHALL register TripleTap=1 at that edge and go to IDLE.
REQ-030 Macro TRIPLE_TAP_EN defined: DoubleTap SHALL be issued only on expiry in TWO.
REQ-031 Macro TRIPLE_TAP_EN not defined: ONE with PulseIn=1 SHALL register DoubleTap=1 at that edge and go to IDLE; state TWO SHALL be unreachable.
REQ-032 Macro TRIPLE_TAP_EN not defined: TripleTap SHALL be constant 0.

Verification (sim=1, WIN=8)
REQ-033 Single pulse at E0, none after -> SingleTap high only in the cycle after E8; Busy high E0..E8; TapCount=1 in that window.
REQ-034 Pulses at E0 and E5, with TRIPLE_TAP_EN -> DoubleTap high only after E13; no SingleTap.
REQ-035 Pulses at E0 and E5, without TRIPLE_TAP_EN -> DoubleTap high only after E5; Busy low after E5.
REQ-036 Pulses at E0, E8, E16 (each on the last legal edge), with TRIPLE_TAP_EN -> TripleTap high only after E16; no other output.
REQ-037 Pulses at E0 and E9 -> SingleTap after E8; new sequence opens at E9 (TapCount=1); SingleTap after E17.
REQ-038 Pulse at E0, reset=0 during cycle 4 for 2 cycles, no further pulses -> all outputs 0 immediately; no SingleTap ever issued.

Source files
------------

// File: rtl/tap_decoder.sv
// -----------------------------------------------------------------------------
// tap_decoder
//
// Purpose:
//   Classifies a burst of button press pulses as a single, double or (when
//   enabled) triple tap. A press opens a sequence. Each further press must
//   arrive within WIN clock edges of the previous one. When the window runs
//   out with no further press, the sequence closes. A one-cycle pulse on the
//   matching tap output then reports how many presses were seen.
//
// Parameters:
//   sim      0 = hardware window (WIN_HW), 1 = short simulation window (WIN_SIM)
//   WIN_HW   tap window in clk cycles for hardware (250 ms at 50 MHz)
//   WIN_SIM  tap window in clk cycles for simulation
//   The selected window must be at least 2.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   PulseIn    in   one-cycle press pulse from the button processing unit
//   SingleTap  out  one-cycle pulse: the sequence held one tap
//   DoubleTap  out  one-cycle pulse: the sequence held two taps
//   TripleTap  out  one-cycle pulse: the sequence held three taps
//   TapCount   out  taps accepted so far in the open sequence (0..2)
//   Busy       out  high while a sequence is open
//
// Configuration macro:
//   TRIPLE_TAP_EN  When defined, a third tap is recognised: the second tap
//                  moves to state TWO, and a tap in TWO gives TripleTap.
//                  When undefined, the second tap gives DoubleTap at once,
//                  state TWO is never entered, and TripleTap stays 0.
// -----------------------------------------------------------------------------
module tap_decoder #(
  parameter int sim     = 0,
  parameter int WIN_HW  = 12500000,
  parameter int WIN_SIM = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PulseIn,
  output logic       SingleTap,
  output logic       DoubleTap,
  output logic       TripleTap,
  output logic [1:0] TapCount,
  output logic       Busy
);

  // Window length actually in use.
  localparam int WIN = (sim != 0) ? WIN_SIM : WIN_HW;

  // The timer only ever has to hold WIN-1. Because WIN >= 2, $clog2(WIN) is
  // at least 1 and already covers that value.
  localparam int TW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(WIN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            single_tap_q, single_tap_d;
  logic            double_tap_q, double_tap_d;
  logic            triple_tap_q, triple_tap_d;
  logic [1:0]      tap_count_q, tap_count_d;
  logic            busy_q, busy_d;

  // The timer counts edges since the last accepted tap. A tap sampled at edge
  // E0 leaves the timer at 0. Before edge Ek the timer therefore reads k-1.
  // This means edge E(WIN) is the last edge that can still take a further tap.
  // If that edge sees no tap, the sequence closes at that same edge.
  // When a tap and an expiry fall on the same edge, the tap takes priority.
  // That is why every branch checks PulseIn before it checks the timer.
  wire timer_expired = (timer_q == TIMER_LAST);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    single_tap_d = 1'b0;
    double_tap_d = 1'b0;
    triple_tap_d = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (PulseIn) begin
          state_d = ONE;
        end
      end

      ONE: begin
        if (PulseIn) begin
          timer_d = '0;
`ifdef TRIPLE_TAP_EN
          state_d = TWO;
`else
          // Without the triple-tap feature the second tap closes the
          // sequence immediately.
          double_tap_d = 1'b1;
          state_d      = IDLE;
`endif
        end else if (timer_expired) begin
          single_tap_d = 1'b1;
          timer_d      = '0;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      TWO: begin
`ifdef TRIPLE_TAP_EN
        if (PulseIn) begin
          triple_tap_d = 1'b1;
          timer_d      = '0;
          state_d      = IDLE;
        end else if (timer_expired) begin
          double_tap_d = 1'b1;
          timer_d      = '0;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`else
        // Never entered in this build. If it is reached anyway, recover
        // quietly to IDLE.
        timer_d = '0;
        state_d = IDLE;
`endif
      end

      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase

    // Busy and TapCount are worked out from the next state. Registering them
    // then keeps them in step with the registered state.
    busy_d = (state_d != IDLE);
    case (state_d)
      ONE:     tap_count_d = 2'd1;
      TWO:     tap_count_d = 2'd2;
      default: tap_count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      single_tap_q <= 1'b0;
      double_tap_q <= 1'b0;
      triple_tap_q <= 1'b0;
      tap_count_q  <= 2'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      single_tap_q <= single_tap_d;
      double_tap_q <= double_tap_d;
      triple_tap_q <= triple_tap_d;
      tap_count_q  <= tap_count_d;
      busy_q       <= busy_d;
    end
  end

  assign SingleTap = single_tap_q;
  assign DoubleTap = double_tap_q;
  assign TripleTap = triple_tap_q;
  assign TapCount  = tap_count_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_tap_decoder.sv
// -----------------------------------------------------------------------------
// tb_tap_decoder
//
// Directed scenarios for tap_decoder, run with sim=1 so that WIN=8.
// Each scenario queues the tap pulses it expects, tagged with kind and edge
// number. A monitor running on the falling clock edge takes each DUT tap pulse
// off the front of that queue and compares them. Busy and TapCount are checked
// directly at chosen points inside each scenario.
// -----------------------------------------------------------------------------
module tb_tap_decoder;

  logic       clk;
  logic       reset;
  logic       PulseIn;
  logic       SingleTap;
  logic       DoubleTap;
  logic       TripleTap;
  logic [1:0] TapCount;
  logic       Busy;

  tap_decoder #(
    .sim     (1),
    .WIN_HW  (12500000),
    .WIN_SIM (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .PulseIn   (PulseIn),
    .SingleTap (SingleTap),
    .DoubleTap (DoubleTap),
    .TripleTap (TripleTap),
    .TapCount  (TapCount),
    .Busy      (Busy)
  );

  localparam int K_SINGLE = 1;
  localparam int K_DOUBLE = 2;
  localparam int K_TRIPLE = 3;

  typedef struct {
    int kind;
    int edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts rising edges. At the falling edge that follows rising edge n,
  // cyc reads n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every tap pulse seen must match the next queued expectation.
  always @(negedge clk) begin
    int   n_high;
    int   kind;
    exp_t e;
    n_high = int'(SingleTap) + int'(DoubleTap) + int'(TripleTap);
    if (n_high > 1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL onehot: %0d tap outputs high at edge %0d, expected at most 1", n_high, cyc);
    end else if (n_high == 1) begin
      kind = SingleTap ? K_SINGLE : (DoubleTap ? K_DOUBLE : K_TRIPLE);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_tap: kind %0d at edge %0d, expected none", kind, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != kind || e.edge_n != cyc) begin
          n_fail++;
          $display("FAIL tap_event: kind %0d at edge %0d, expected kind %0d at edge %0d",
                   kind, cyc, e.kind, e.edge_n);
        end else begin
          $display("tap kind %0d at edge %0d ok", kind, cyc);
        end
      end
    end
  end

  // Drives the relative edges a..b, taking the press pattern from mask m.
  // The call must start at a falling edge, and it ends at one.
  task automatic run(input logic [31:0] m, input int a, input int b);
    for (int k = a; k <= b; k++) begin
      PulseIn = m[k];
      @(negedge clk);
    end
    PulseIn = 1'b0;
  endtask

  task automatic expect_tap(input int kind, input int edge_n);
    exp_t e;
    e.kind   = kind;
    e.edge_n = edge_n;
    exp_q.push_back(e);
  endtask

  initial begin
    int e0;
    logic [31:0] m;

    reset   = 1'b0;
    PulseIn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_single", int'(SingleTap), 0);
    chk("rst_double", int'(DoubleTap), 0);
    chk("rst_triple", int'(TripleTap), 0);
    chk("rst_count",  int'(TapCount),  0);
    chk("rst_busy",   int'(Busy),      0);
    reset = 1'b1;
    @(negedge clk);

    // S1: one press at E0. SingleTap follows at E8.
    e0 = cyc + 1;
    m  = 32'h1;
    expect_tap(K_SINGLE, e0 + 8);
    run(m, 0, 0);
    chk("s1_busy_e0",  int'(Busy), 1);
    chk("s1_cnt_e0",   int'(TapCount), 1);
    run(m, 1, 7);
    chk("s1_busy_e7",  int'(Busy), 1);
    chk("s1_cnt_e7",   int'(TapCount), 1);
    run(m, 8, 8);
    chk("s1_busy_e8",  int'(Busy), 0);
    chk("s1_cnt_e8",   int'(TapCount), 0);
    run(m, 9, 11);

    // S2: presses at E0 and E5.
    e0 = cyc + 1;
    m  = 32'h21;
`ifdef TRIPLE_TAP_EN
    expect_tap(K_DOUBLE, e0 + 13);
    run(m, 0, 5);
    chk("s2_cnt_e5",  int'(TapCount), 2);
    chk("s2_busy_e5", int'(Busy), 1);
`else
    expect_tap(K_DOUBLE, e0 + 5);
    run(m, 0, 5);
    chk("s2_cnt_e5",  int'(TapCount), 0);
    chk("s2_busy_e5", int'(Busy), 0);
`endif
    run(m, 6, 16);

    // S3: presses at E0, E8 and E16, each on the last edge that still counts.
    e0 = cyc + 1;
    m  = 32'h10101;
`ifdef TRIPLE_TAP_EN
    expect_tap(K_TRIPLE, e0 + 16);
`else
    expect_tap(K_DOUBLE, e0 + 8);
    expect_tap(K_SINGLE, e0 + 24);
`endif
    run(m, 0, 8);
`ifdef TRIPLE_TAP_EN
    chk("s3_cnt_e8", int'(TapCount), 2);
`else
    chk("s3_cnt_e8", int'(TapCount), 0);
`endif
    run(m, 9, 26);

    // S4: presses at E0 and E9. E9 comes one edge too late, so the first
    // sequence has already closed and E9 opens a new one.
    e0 = cyc + 1;
    m  = 32'h201;
    expect_tap(K_SINGLE, e0 + 8);
    expect_tap(K_SINGLE, e0 + 17);
    run(m, 0, 9);
    chk("s4_cnt_e9",  int'(TapCount), 1);
    chk("s4_busy_e9", int'(Busy), 1);
    run(m, 10, 19);

    // S5: press at E0, then a reset in the middle of the sequence. Nothing may
    // be emitted for the sequence that was discarded.
    m = 32'h1;
    run(m, 0, 3);
    chk("s5_busy_pre", int'(Busy), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("s5_busy_async", int'(Busy), 0);
    chk("s5_cnt_async",  int'(TapCount), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run(32'h0, 0, 12);
    chk("s5_busy_after", int'(Busy), 0);

    // S6: PulseIn held high for three cycles, which counts as three taps.
    e0 = cyc + 1;
    m  = 32'h7;
`ifdef TRIPLE_TAP_EN
    expect_tap(K_TRIPLE, e0 + 2);
`else
    expect_tap(K_DOUBLE, e0 + 1);
    expect_tap(K_SINGLE, e0 + 10);
`endif
    run(m, 0, 12);

    chk("pending_taps", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
